hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Pipeline hazard and forwarding controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Produces the NOP-select that forces the ID-stage control signals to zero.
- Produces PC and IF/ID load enables, the IF/ID flush, and operand forwarding selects.
- Keeps its own shadow copy of destination register, write-enable and load flags for EX, MEM and WB. It therefore needs only ID-stage inputs plus the branch outcome.

Parameters:
- REG_W, 4, register index width.
- PC_REG, 15, register index that is never forwarded (PC reads come from the fetch path).
- CNT_W, 8, width of the stall performance counter.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- ID_Rn  input  REG_W  first source register of the instruction in ID
- ID_Rm  input  REG_W  second source register
- ID_Rd_src  input  REG_W  store-data source register (Rd read by stores)
- ID_use_rn  input  1  instruction in ID reads Rn
- ID_use_rm  input  1  instruction in ID reads Rm
- ID_use_rd  input  1  instruction in ID reads Rd (store data)
- ID_Rd  input  REG_W  destination register of the instruction in ID
- ID_RF_enable  input  1  instruction in ID writes the register file
- ID_load_instr  input  1  instruction in ID is a load
- branch_taken  input  1  branch or BL in ID resolved taken this cycle
- nop_sel  output  1  forces the ID control signals to zero (bubble into EX)
- pc_le  output  1  PC load enable
- ifid_le  output  1  IF/ID register load enable
- ifid_clr  output  1  IF/ID synchronous clear (flush)
- fwd_a  output  2  Rn operand select
- fwd_b  output  2  Rm operand select
- fwd_c  output  2  Rd (store data) operand select
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles
- stalled  output  1  registered; high when the previous cycle was a stall

Behaviour:
Shadow pipeline (updated on the rising edge of clk; all fields cleared by reset):
- ex_rd, ex_we, ex_ld load from ID_Rd, ID_RF_enable and ID_load_instr.
- When nop_sel=1 they load 0, 0, 0 instead, because a bubble writes nothing.
- Each edge: mem fields take the EX values; wb fields take the MEM values. Updates happen every cycle and are never frozen.

Load-use hazard, `lu` (combinational):
- `lu` = ex_ld & ex_we & ex_rd!=PC_REG & ((ID_use_rn & ID_Rn==ex_rd) | (ID_use_rm & ID_Rm==ex_rd) | (ID_use_rd & ID_Rd_src==ex_rd)).

Outputs while `lu`=1:
- nop_sel=1, pc_le=0, ifid_le=0, ifid_clr=0.
- Exactly one bubble is inserted. On the next cycle the load sits in MEM and is forwarded.

Forwarding, per operand (combinational):
- Select the first match in this priority order:
  - EX: ex_we & ex_rd==src & !ex_ld -> 01
  - MEM: mem_we & mem_rd==src -> 10
  - WB: wb_we & wb_rd==src -> 11
  - otherwise -> 00
- src==PC_REG always gives 00.
- When the matching operand's use flag is 0, its select is 00.

Branch flush:
- branch_taken & !lu: ifid_clr=1 for one cycle; pc_le=1, ifid_le=1.
- branch_taken & lu: the stall wins and ifid_clr=0. The branch stays in ID and is re-resolved next cycle.

State machine (2 states, registered, reset to RUN):
- RUN -> STALL when `lu`.
- STALL -> RUN unconditionally.
- A second consecutive `lu` in STALL stays in STALL. This cannot happen with a valid shadow pipeline, but RTL must handle it.
- stalled = (state==STALL).

stall_cnt:
- Increments on every edge where `lu`=1.
- Saturates at 2^CNT_W-1 with no wrap.

Reset (asynchronous, active-low):
- Clears all shadow fields, sets state to RUN and stall_cnt to 0.
- Resulting outputs: nop_sel=0, pc_le=1, ifid_le=1, ifid_clr=0, fwd_a=fwd_b=fwd_c=00, stalled=0.
- Reset asserted mid-stall releases the stall immediately (asynchronously).

Test Plan:
- LDR R1 in EX (ex_ld=1, ex_rd=1) and ID ADD reads Rn=1 -> nop_sel=1, pc_le=0, ifid_le=0, stall_cnt 0->1. Next cycle: nop_sel=0, fwd_a=10 (MEM), stalled=1.
- ADD R2 then SUB reading R2 (Rm) -> fwd_b=01. After an intervening NOP -> fwd_b=10. After two NOPs -> 11. After three -> 00.
- R3 written in EX and also in MEM, ID reads R3 -> fwd_a=01 (EX priority). Any instruction with a source of R15 -> its select is 00 regardless of writers.
- branch_taken=1 with no hazard -> ifid_clr=1 for exactly one cycle, pc_le=1. branch_taken=1 together with a load-use hazard -> ifid_clr=0, nop_sel=1; the next cycle gives ifid_clr=1.
- Force 300 load-use cycles with CNT_W=8 -> stall_cnt holds at 255.
- Assert reset_n=0 while `lu` is active -> outputs return to their reset values asynchronously, stall_cnt=0, and all shadow fields are cleared.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
//
// Hazard detection and operand-forwarding controller for a 5-stage
// (IF, ID, EX, MEM, WB) core.
//
// The unit keeps its own shadow copy of the destination register,
// write-enable and load flags for the instructions in EX, MEM and WB.
// Because of that, it only needs the ID-stage decode fields and the branch
// outcome as inputs.
//
// Parameters
//   REG_W   register index width
//   PC_REG  register index that is never forwarded (PC reads come from fetch)
//   CNT_W   width of the saturating load-use stall counter
//
// Ports
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   ID_Rn/Rm/Rd_src   source registers of the instruction in ID
//   ID_use_rn/rm/rd   which of those sources the instruction actually reads
//   ID_Rd             destination register of the instruction in ID
//   ID_RF_enable      instruction in ID writes the register file
//   ID_load_instr     instruction in ID is a load
//   branch_taken      branch/BL in ID resolved taken this cycle
//   nop_sel           zero the ID control word (bubble into EX)
//   pc_le, ifid_le    PC and IF/ID load enables
//   ifid_clr          IF/ID synchronous flush
//   fwd_a/b/c         operand selects for Rn, Rm, Rd (store data):
//                     00 = register file, 01 = EX, 10 = MEM, 11 = WB
//   stall_cnt         saturating count of load-use stall cycles
//   stalled           high when the previous cycle was a load-use stall
// ---------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] ID_Rn,
  input  logic [REG_W-1:0] ID_Rm,
  input  logic [REG_W-1:0] ID_Rd_src,
  input  logic             ID_use_rn,
  input  logic             ID_use_rm,
  input  logic             ID_use_rd,
  input  logic [REG_W-1:0] ID_Rd,
  input  logic             ID_RF_enable,
  input  logic             ID_load_instr,
  input  logic             branch_taken,
  output logic             nop_sel,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stalled
);

  localparam logic [REG_W-1:0] PC_IDX   = REG_W'(PC_REG);

  localparam logic [0:0]       ST_RUN   = 1'b0;
  localparam logic [0:0]       ST_STALL = 1'b1;

  localparam logic [1:0]       SEL_RF   = 2'b00;
  localparam logic [1:0]       SEL_EX   = 2'b01;
  localparam logic [1:0]       SEL_MEM  = 2'b10;
  localparam logic [1:0]       SEL_WB   = 2'b11;

  // Shadow pipeline. Only EX needs the load flag: a load result becomes
  // forwardable once it reaches MEM, so MEM and WB track only rd/we.
  logic [REG_W-1:0] ex_rd;
  logic             ex_we;
  logic             ex_ld;
  logic [REG_W-1:0] mem_rd;
  logic             mem_we;
  logic [REG_W-1:0] wb_rd;
  logic             wb_we;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             lu;
  logic             hit_rn;
  logic             hit_rm;
  logic             hit_rd;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  // Forwarding select for one operand. The nearest producer wins. A load
  // in EX is skipped because its data does not exist yet. That case is
  // covered by the load-use stall, after which the load sits in MEM.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             use_f,
    input logic [REG_W-1:0] e_rd,
    input logic             e_we,
    input logic             e_ld,
    input logic [REG_W-1:0] m_rd,
    input logic             m_we,
    input logic [REG_W-1:0] w_rd,
    input logic             w_we
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_f && (src != PC_IDX)) begin
      if (e_we && (e_rd == src) && !e_ld) begin
        sel = SEL_EX;
      end else if (m_we && (m_rd == src)) begin
        sel = SEL_MEM;
      end else if (w_we && (w_rd == src)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  // ---- ID stage: load-use detection against the instruction in EX ----
  assign hit_rn = ID_use_rn && (ID_Rn     == ex_rd);
  assign hit_rm = ID_use_rm && (ID_Rm     == ex_rd);
  assign hit_rd = ID_use_rd && (ID_Rd_src == ex_rd);

  assign lu = ex_ld && ex_we && (ex_rd != PC_IDX) && (hit_rn || hit_rm || hit_rd);

  // A load-use stall freezes PC and IF/ID and injects one bubble. It also
  // overrides a taken branch. The branch stays in ID and resolves again
  // on the next cycle, and that later resolution performs the flush.
  assign nop_sel  = lu;
  assign pc_le    = !lu;
  assign ifid_le  = !lu;
  assign ifid_clr = branch_taken && !lu;

  assign fwd_a = fwd_sel(ID_Rn, ID_use_rn, ex_rd, ex_we, ex_ld,
                         mem_rd, mem_we, wb_rd, wb_we);
  assign fwd_b = fwd_sel(ID_Rm, ID_use_rm, ex_rd, ex_we, ex_ld,
                         mem_rd, mem_we, wb_rd, wb_we);
  assign fwd_c = fwd_sel(ID_Rd_src, ID_use_rd, ex_rd, ex_we, ex_ld,
                         mem_rd, mem_we, wb_rd, wb_we);

  // ---- ID -> EX -> MEM -> WB shadow register boundary ----
  // The shadow pipeline never freezes. During a stall, the bubble (all
  // zeros) enters EX while older instructions keep draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rd  <= '0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_rd <= '0;
      mem_we <= 1'b0;
      wb_rd  <= '0;
      wb_we  <= 1'b0;
    end else begin
      if (nop_sel) begin
        ex_rd <= '0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
      end else begin
        ex_rd <= ID_Rd;
        ex_we <= ID_RF_enable;
        ex_ld <= ID_load_instr;
      end
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
    end
  end

  // Stall state. Staying in STALL on back-to-back hazards cannot occur with
  // a consistent shadow pipeline, but it is handled for robustness.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   state_nxt = lu ? ST_STALL : ST_RUN;
      ST_STALL: state_nxt = lu ? ST_STALL : ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // ---- control register boundary ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (lu) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign stalled = (state == ST_STALL);

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  localparam int REG_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [REG_W-1:0] ID_Rn = '0, ID_Rm = '0, ID_Rd_src = '0, ID_Rd = '0;
  logic             ID_use_rn = 0, ID_use_rm = 0, ID_use_rd = 0;
  logic             ID_RF_enable = 0, ID_load_instr = 0, branch_taken = 0;
  logic             nop_sel, pc_le, ifid_le, ifid_clr, stalled;
  logic [1:0]       fwd_a, fwd_b, fwd_c;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_fwd_unit #(.REG_W(REG_W), .PC_REG(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd_src(ID_Rd_src),
    .ID_use_rn(ID_use_rn), .ID_use_rm(ID_use_rm), .ID_use_rd(ID_use_rd),
    .ID_Rd(ID_Rd), .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr),
    .branch_taken(branch_taken),
    .nop_sel(nop_sel), .pc_le(pc_le), .ifid_le(ifid_le), .ifid_clr(ifid_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall_cnt(stall_cnt), .stalled(stalled)
  );

  always #5 clk = ~clk;

  // Reference model: history of the last three issued instructions
  // (index 0 = EX, 1 = MEM, 2 = WB), plus the stall count and the last
  // cycle's hazard flag.
  logic [3:0] m_rd [3];
  logic       m_we [3];
  logic       m_ld [3];
  int         m_cnt;
  logic       m_stalled;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rd[k] = '0; m_we[k] = 1'b0; m_ld[k] = 1'b0;
    end
    m_cnt = 0;
    m_stalled = 1'b0;
  endtask

  function automatic logic m_lu();
    logic hit;
    hit = (ID_use_rn && ID_Rn == m_rd[0]) || (ID_use_rm && ID_Rm == m_rd[0]) ||
          (ID_use_rd && ID_Rd_src == m_rd[0]);
    return m_ld[0] && m_we[0] && (m_rd[0] != 4'd15) && hit;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [3:0] src, input logic use_f);
    if (!use_f || src == 4'd15) return 2'b00;
    for (int k = 0; k < 3; k++) begin
      if (m_we[k] && m_rd[k] == src && !(k == 0 && m_ld[k])) return 2'(k + 1);
    end
    return 2'b00;
  endfunction

  // Advance the model with the inputs currently applied, then take the edge.
  task automatic tick();
    logic lu;
    lu = m_lu();
    if (lu) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    m_stalled = lu;
    for (int k = 2; k > 0; k--) begin
      m_rd[k] = m_rd[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_rd[0] = lu ? 4'd0 : ID_Rd;
    m_we[0] = lu ? 1'b0 : ID_RF_enable;
    m_ld[0] = lu ? 1'b0 : ID_load_instr;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [3:0] rn, rm, rds, input logic urn, urm, urd,
                        input logic [3:0] rd, input logic we, ld, br);
    ID_Rn = rn; ID_Rm = rm; ID_Rd_src = rds;
    ID_use_rn = urn; ID_use_rm = urm; ID_use_rd = urd;
    ID_Rd = rd; ID_RF_enable = we; ID_load_instr = ld; branch_taken = br;
    #1;
  endtask

  task automatic set_nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    set_nop();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({nop_sel, pc_le, ifid_le, ifid_clr} !== 4'b0110) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0110", {nop_sel, pc_le, ifid_le, ifid_clr});
    end
    n_cmp++;
    if ({fwd_a, fwd_b, fwd_c, stalled} !== 7'b0) begin
      n_fail++; $display("FAIL reset_fwd_stalled: got %b want 0000000", {fwd_a, fwd_b, fwd_c, stalled});
    end
    n_cmp++;
    if (stall_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);   // LDR R1
    tick();
    set_id(1, 0, 0, 1, 0, 0, 4, 1, 0, 0);   // ADD R4, R1, ...
    n_cmp++;
    if ({nop_sel, pc_le, ifid_le, ifid_clr} !== 4'b1000 || stall_cnt !== 8'd0) begin
      n_fail++; $display("FAIL lu_stall: ctrl %b cnt %0d want 1000 cnt 0",
                         {nop_sel, pc_le, ifid_le, ifid_clr}, stall_cnt);
    end
    tick();
    n_cmp++;
    if ({nop_sel, pc_le, ifid_le, ifid_clr} !== 4'b0110 || fwd_a !== 2'b10) begin
      n_fail++; $display("FAIL lu_after: ctrl %b fwd_a %b want 0110 fwd_a 10",
                         {nop_sel, pc_le, ifid_le, ifid_clr}, fwd_a);
    end
    n_cmp++;
    if (stalled !== 1'b1 || stall_cnt !== 8'd1) begin
      n_fail++; $display("FAIL lu_stalled_cnt: stalled %b cnt %0d want 1 cnt 1", stalled, stall_cnt);
    end
    tick();
    n_cmp++;
    if (stalled !== 1'b0) begin
      n_fail++; $display("FAIL lu_release: stalled %b want 0", stalled);
    end
  endtask

  task automatic test_fwd_distance();
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b11; want[3] = 2'b00;
    for (int d = 0; d < 4; d++) begin
      do_reset();
      set_id(0, 0, 0, 0, 0, 0, 2, 1, 0, 0);   // ADD R2
      tick();
      for (int n = 0; n < d; n++) begin
        set_nop();
        tick();
      end
      set_id(0, 2, 0, 0, 1, 0, 5, 1, 0, 0);   // SUB R5, x, R2
      n_cmp++;
      if (fwd_b !== want[d]) begin
        n_fail++; $display("FAIL fwd_dist%0d: fwd_b %b want %b", d, fwd_b, want[d]);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    set_id(3, 3, 3, 1, 1, 1, 6, 1, 0, 0);
    n_cmp++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b010101) begin
      n_fail++; $display("FAIL fwd_ex_priority: got %b want 010101", {fwd_a, fwd_b, fwd_c});
    end
    set_id(3, 3, 3, 0, 1, 0, 6, 1, 0, 0);
    n_cmp++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b000100) begin
      n_fail++; $display("FAIL fwd_use_flag: got %b want 000100", {fwd_a, fwd_b, fwd_c});
    end
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 15, 1, 0, 0);
    tick();
    tick();
    set_id(15, 15, 15, 1, 1, 1, 6, 1, 0, 0);
    n_cmp++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b000000) begin
      n_fail++; $display("FAIL fwd_pc_reg: got %b want 000000", {fwd_a, fwd_b, fwd_c});
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({nop_sel, pc_le, ifid_le, ifid_clr} !== 4'b0111) begin
      n_fail++; $display("FAIL br_flush: got %b want 0111", {nop_sel, pc_le, ifid_le, ifid_clr});
    end
    tick();
    set_nop();
    n_cmp++;
    if (ifid_clr !== 1'b0) begin
      n_fail++; $display("FAIL br_one_cycle: ifid_clr %b want 0", ifid_clr);
    end
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);   // LDR R1
    tick();
    set_id(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);   // taken branch reading R1
    n_cmp++;
    if ({nop_sel, pc_le, ifid_le, ifid_clr} !== 4'b1000) begin
      n_fail++; $display("FAIL br_vs_lu: got %b want 1000", {nop_sel, pc_le, ifid_le, ifid_clr});
    end
    tick();
    n_cmp++;
    if ({nop_sel, pc_le, ifid_le, ifid_clr} !== 4'b0111) begin
      n_fail++; $display("FAIL br_retry: got %b want 0111", {nop_sel, pc_le, ifid_le, ifid_clr});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    // A load that reads its own destination stalls on every other cycle.
    set_id(1, 0, 0, 1, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 640; i++) tick();
    n_cmp++;
    if (stall_cnt !== 8'd255) begin
      n_fail++; $display("FAIL cnt_saturate: got %0d want 255", stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 1, 0, 0, 1, 1, 1, 0);
    tick();
    tick();                                 // stall active again, cnt = 1
    n_cmp++;
    if (nop_sel !== 1'b1 || stall_cnt !== 8'd1) begin
      n_fail++; $display("FAIL arst_setup: nop_sel %b cnt %0d want 1 cnt 1", nop_sel, stall_cnt);
    end
    reset_n = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if ({nop_sel, pc_le, ifid_le, ifid_clr, fwd_a, stalled} !== 7'b0110000 || stall_cnt !== 8'd0) begin
      n_fail++; $display("FAIL arst_async: got %b cnt %0d want 0110000 cnt 0",
                         {nop_sel, pc_le, ifid_le, ifid_clr, fwd_a, stalled}, stall_cnt);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (nop_sel !== 1'b0 || fwd_a !== 2'b00) begin
      n_fail++; $display("FAIL arst_shadow_clear: nop_sel %b fwd_a %b want 0 00", nop_sel, fwd_a);
    end
  endtask

  task automatic test_random();
    logic [3:0] r [4];
    logic       lu;
    logic [18:0] want, got;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 4; k++) begin
        r[k] = 4'($urandom_range(0, 4));
        if (r[k] == 4'd4) r[k] = 4'd15;
      end
      set_id(r[0], r[1], r[2], 1'($urandom), 1'($urandom), 1'($urandom),
             r[3], 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 7) == 0));
      lu = m_lu();
      want = {lu, !lu, !lu, branch_taken && !lu, m_fwd(ID_Rn, ID_use_rn),
              m_fwd(ID_Rm, ID_use_rm), m_fwd(ID_Rd_src, ID_use_rd), m_stalled, 8'(m_cnt)};
      got  = {nop_sel, pc_le, ifid_le, ifid_clr, fwd_a, fwd_b, fwd_c, stalled, stall_cnt};
      n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", i, got, want);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_fwd_distance();
    test_priority();
    test_branch();
    test_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
